// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: sequencing controller for the AES decipher round datapath.
// Holds round keys, starts the core, answers key requests, buffers plaintext.
module aes_dec_ctrl #(
    parameter int BLK_S      = 128,
    parameter int RK_BITS    = 128,
    parameter int CNT_W      = 4,
    parameter int MAX_ROUNDS = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_wr_en,
    input  logic [CNT_W-1:0]   key_wr_addr,
    input  logic [RK_BITS-1:0] key_wr_data,
    output logic               key_wr_ready,
    input  logic               cfg_load,
    input  logic [CNT_W-1:0]   rounds_cfg,
    output logic               cfg_err,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLK_S-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLK_S-1:0]   m_data,
    output logic               busy,
    output logic               dec_en,
    output logic [BLK_S-1:0]   dec_ciphertext,
    output logic [CNT_W-1:0]   dec_rounds,
    output logic [RK_BITS-1:0] dec_key,
    output logic               dec_key_valid,
    input  logic               dec_key_req,
    input  logic [CNT_W-1:0]   dec_round_key_no,
    input  logic [BLK_S-1:0]   dec_plaintext,
    input  logic               dec_en_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [RK_BITS-1:0] r_store [0:MAX_ROUNDS];

    logic               r_keys_ok;
    logic               r_m_valid;
    logic [BLK_S-1:0]   r_m_data;
    logic [BLK_S-1:0]   r_ct;
    logic [CNT_W-1:0]   r_rounds;
    logic [RK_BITS-1:0] r_key;
    logic               r_key_valid;
    logic               r_cfg_err;

    logic w_idle;
    logic w_run;
    logic w_accept;
    logic w_key_wr;
    logic w_cfg;
    logic w_cfg_ok;
    logic w_rd_ok;
    logic w_done;
    logic w_dec_en;

    assign w_idle   = (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign s_ready  = w_idle & r_keys_ok & (~r_m_valid | m_ready);
    assign w_accept = s_valid & s_ready;
    assign w_key_wr = key_wr_en & w_idle
                    & (key_wr_addr <= CNT_W'(MAX_ROUNDS));
    assign w_cfg    = cfg_load & w_idle;
    assign w_cfg_ok = (rounds_cfg == CNT_W'(10))
                    | (rounds_cfg == CNT_W'(12))
                    | (rounds_cfg == CNT_W'(14));
    assign w_rd_ok  = (dec_round_key_no <= CNT_W'(MAX_ROUNDS));
    assign w_done   = w_run & dec_en_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dec_en    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_dec_en    = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (dec_en_o) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key contents survive reset; only the usable flag is cleared.
    always_ff @(posedge clk) begin
        if (w_key_wr) begin
            r_store[key_wr_addr] <= key_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_ok <= 1'b0;
            r_rounds  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg & ~w_cfg_ok;
            if (w_key_wr) begin
                r_keys_ok <= 1'b0;
            end
            if (w_cfg) begin
                r_keys_ok <= w_cfg_ok;
                if (w_cfg_ok) begin
                    r_rounds <= rounds_cfg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ct        <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ct <= s_data;
            end
            r_key_valid <= w_run & dec_key_req;
            if (w_run && dec_key_req) begin
                r_key <= w_rd_ok ? r_store[dec_round_key_no] : '0;
            end
        end
    end

    // Output register; a drain and a new capture never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_done) begin
            r_m_valid <= 1'b1;
            r_m_data  <= dec_plaintext;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign key_wr_ready   = w_idle;
    assign cfg_err        = r_cfg_err;
    assign m_valid        = r_m_valid;
    assign m_data         = r_m_data;
    assign busy           = ~w_idle;
    assign dec_en         = w_dec_en;
    assign dec_ciphertext = r_ct;
    assign dec_rounds     = r_rounds;
    assign dec_key        = r_key;
    assign dec_key_valid  = r_key_valid;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl with a behavioural decipher-core responder.
// The responder checks delivered round keys and returns a tagged plaintext.
module tb_aes_dec_ctrl;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BADPT = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    localparam logic [127:0] CTA   = 128'h0123456789abcdef0011223344556677;
    localparam logic [127:0] CTB   = 128'hfedcba98765432100f1e2d3c4b5a6978;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_wr_en;
    logic [3:0]   key_wr_addr;
    logic [127:0] key_wr_data;
    logic         key_wr_ready;
    logic         cfg_load;
    logic [3:0]   rounds_cfg;
    logic         cfg_err;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         busy;
    logic         dec_en;
    logic [127:0] dec_ciphertext;
    logic [3:0]   dec_rounds;
    logic [127:0] dec_key;
    logic         dec_key_valid;
    logic         dec_key_req;
    logic [3:0]   dec_round_key_no;
    logic [127:0] dec_plaintext;
    logic         dec_en_o;

    int total = 0;
    int bad   = 0;

    logic [127:0] tb_keys [0:14];
    int           kv_count = 0;
    int           cm_idx   = 0;
    logic         cm_ok    = 1'b0;
    logic [127:0] cm_ct    = '0;

    always #5 clk = ~clk;

    aes_dec_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .key_wr_en        (key_wr_en),
        .key_wr_addr      (key_wr_addr),
        .key_wr_data      (key_wr_data),
        .key_wr_ready     (key_wr_ready),
        .cfg_load         (cfg_load),
        .rounds_cfg       (rounds_cfg),
        .cfg_err          (cfg_err),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .dec_en           (dec_en),
        .dec_ciphertext   (dec_ciphertext),
        .dec_rounds       (dec_rounds),
        .dec_key          (dec_key),
        .dec_key_valid    (dec_key_valid),
        .dec_key_req      (dec_key_req),
        .dec_round_key_no (dec_round_key_no),
        .dec_plaintext    (dec_plaintext),
        .dec_en_o         (dec_en_o)
    );

    function automatic logic [127:0] model_pt(input logic [127:0] ct);
        if (ct == CT128 || ct == CT256) return PT;
        return ~ct;
    endfunction

    // Decipher responder: requests keys Nr..0 back to back, then signals done.
    always @(posedge clk) begin
        dec_en_o <= 1'b0;
        if (reset) begin
            dec_key_req <= 1'b0;
        end else begin
            if (dec_key_req) begin
                if (dec_round_key_no == 4'd0) dec_key_req <= 1'b0;
                else dec_round_key_no <= dec_round_key_no - 4'd1;
            end
            if (dec_key_valid) begin
                kv_count <= kv_count + 1;
                if (dec_key !== tb_keys[cm_idx]) cm_ok <= 1'b0;
                if (cm_idx == 0) begin
                    dec_en_o      <= 1'b1;
                    dec_plaintext <= (cm_ok && dec_key === tb_keys[0])
                                   ? model_pt(cm_ct) : BADPT;
                end
                cm_idx <= cm_idx - 1;
            end
            if (dec_en) begin
                dec_key_req      <= 1'b1;
                dec_round_key_no <= dec_rounds;
                cm_idx           <= int'(dec_rounds);
                cm_ok            <= 1'b1;
                cm_ct            <= dec_ciphertext;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wkey(input logic [3:0] a, input logic [127:0] d);
        key_wr_en   = 1'b1;
        key_wr_addr = a;
        key_wr_data = d;
        cyc();
        key_wr_en   = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] nr);
        cfg_load   = 1'b1;
        rounds_cfg = nr;
        cyc();
        cfg_load   = 1'b0;
    endtask

    // Returns in cycle 1 after the handshake (cycle 0).
    task automatic send(input logic [127:0] ct);
        int n;
        s_valid = 1'b1;
        s_data  = ct;
        #1;
        n = 0;
        while (!s_ready && n < 30) begin
            cyc();
            n++;
        end
        chk("handshake_ready", {127'd0, s_ready}, 128'd1);
        cyc();
        s_valid = 1'b0;
    endtask

    // Counts from cycle 1 until m_valid, bounded.
    task automatic wait_mv(output int n);
        n = 1;
        while (!m_valid && n < 40) begin
            cyc();
            n++;
        end
    endtask

    int n;
    int kv0;

    initial begin
        reset       = 1'b1;
        key_wr_en   = 1'b0;
        key_wr_addr = '0;
        key_wr_data = '0;
        cfg_load    = 1'b0;
        rounds_cfg  = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        tb_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        tb_keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        tb_keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        tb_keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        tb_keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        tb_keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        tb_keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        tb_keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        tb_keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        tb_keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        tb_keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 15; i++) tb_keys[i] = '0;
        cyc();
        cyc();
        cyc();
        reset = 1'b0;

        // reset state
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
        chk("rst_key_valid", {127'd0, dec_key_valid}, 128'd0);
        chk("rst_cfg_err", {127'd0, cfg_err}, 128'd0);
        chk("rst_dec_en", {127'd0, dec_en}, 128'd0);
        chk("rst_m_data", m_data, 128'd0);
        chk("rst_ct", dec_ciphertext, 128'd0);
        chk("rst_rounds", {124'd0, dec_rounds}, 128'd0);
        chk("rst_key", dec_key, 128'd0);
        chk("rst_wr_ready", {127'd0, key_wr_ready}, 128'd1);
        s_valid = 1'b1;
        #1;
        chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
        s_valid = 1'b0;

        // AES-128 decrypt
        for (int i = 0; i < 11; i++) wkey(4'(i), tb_keys[i]);
        cfg(4'd10);
        chk("t1_rounds", {124'd0, dec_rounds}, 128'd10);
        kv0 = kv_count;
        send(CT128);
        chk("t1_dec_en", {127'd0, dec_en}, 128'd1);
        chk("t1_ct_held", dec_ciphertext, CT128);
        wait_mv(n);
        chk("t1_latency", 128'(n), 128'd15);
        chk("t1_m_data", m_data, PT);
        chk("t1_key_pulses", 128'(kv_count - kv0), 128'd11);
        chk("t1_idle", {127'd0, busy}, 128'd0);
        cyc();
        chk("t1_drain", {127'd0, m_valid}, 128'd0);

        // key write during RUN dropped
        send(CT128);
        cyc();
        cyc();
        key_wr_en   = 1'b1;
        key_wr_addr = 4'd3;
        key_wr_data = {128{1'b1}};
        #1;
        chk("t5_wr_ready_run", {127'd0, key_wr_ready}, 128'd0);
        cyc();
        key_wr_en = 1'b0;
        wait_mv(n);
        chk("t5_m_data", m_data, PT);
        cyc();
        wkey(4'd15, {128{1'b1}});
        s_valid = 1'b1;
        #1;
        chk("t5_keys_ok_kept", {127'd0, s_ready}, 128'd1);
        send(CT128);
        wait_mv(n);
        chk("t5_m_data2", m_data, PT);
        cyc();

        // backpressure, back-to-back blocks
        m_ready = 1'b0;
        send(CTA);
        wait_mv(n);
        chk("t3_latency_a", 128'(n), 128'd15);
        s_valid = 1'b1;
        s_data  = CTB;
        #1;
        chk("t3_blocked", {127'd0, s_ready}, 128'd0);
        cyc();
        cyc();
        cyc();
        chk("t3_hold_data", m_data, ~CTA);
        chk("t3_hold_valid", {127'd0, m_valid}, 128'd1);
        chk("t3_still_blocked", {127'd0, s_ready}, 128'd0);
        m_ready = 1'b1;
        #1;
        chk("t3_ready_same_cyc", {127'd0, s_ready}, 128'd1);
        cyc();
        s_valid = 1'b0;
        chk("t3_drained", {127'd0, m_valid}, 128'd0);
        chk("t3_dec_en_b", {127'd0, dec_en}, 128'd1);
        chk("t3_ct_b", dec_ciphertext, CTB);
        wait_mv(n);
        chk("t3_latency_b", 128'(n), 128'd15);
        chk("t3_m_data_b", m_data, ~CTB);
        cyc();

        // reset mid-operation
        send(CT128);
        for (int i = 1; i < 6; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_busy", {127'd0, busy}, 128'd0);
        chk("t6_m_valid", {127'd0, m_valid}, 128'd0);
        chk("t6_key_valid", {127'd0, dec_key_valid}, 128'd0);
        s_valid = 1'b1;
        #1;
        chk("t6_s_ready", {127'd0, s_ready}, 128'd0);
        for (int i = 0; i < 20; i++) cyc();
        chk("t6_no_output", {127'd0, m_valid}, 128'd0);
        s_valid = 1'b0;
        cfg(4'd10);
        send(CT128);
        wait_mv(n);
        chk("t6_latency", 128'(n), 128'd15);
        chk("t6_m_data", m_data, PT);
        cyc();

        // illegal round count
        cfg_load   = 1'b1;
        rounds_cfg = 4'd11;
        cyc();
        cfg_load = 1'b0;
        chk("t4_cfg_err", {127'd0, cfg_err}, 128'd1);
        s_valid = 1'b1;
        #1;
        chk("t4_s_ready", {127'd0, s_ready}, 128'd0);
        cyc();
        chk("t4_err_pulse", {127'd0, cfg_err}, 128'd0);
        chk("t4_s_ready2", {127'd0, s_ready}, 128'd0);
        chk("t4_rounds_kept", {124'd0, dec_rounds}, 128'd10);
        s_valid = 1'b0;

        // 14-round decrypt with a full key store
        for (int i = 0; i < 15; i++) begin
            tb_keys[i] = {16{8'(8'h11 * i + 8'h0f)}};
            wkey(4'(i), tb_keys[i]);
        end
        cfg(4'd14);
        chk("t2_rounds", {124'd0, dec_rounds}, 128'd14);
        kv0 = kv_count;
        send(CT256);
        wait_mv(n);
        chk("t2_latency", 128'(n), 128'd19);
        chk("t2_m_data", m_data, PT);
        chk("t2_key_pulses", 128'(kv_count - kv0), 128'd15);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
